pll_clk_div_bank: RTL and testbench
===================================

// Module: pll_clk_div_bank
// PURPOSE
//  Parametrised clock-enable/divider bank behind the PLL wrapper. It qualifies the PLL
//  'locked' flag (sync + stability wait) and generates NUM_CH phase-aligned divided
//  clocks and clock-enable pulses in the refclk domain. Divisors and phases are runtime
//  programmable. This replaces fixed per-frequency PLL instances for slow derived clocks.
// PARAMETERS
//  NUM_CH      4     number of output channels (1..16)
//  DIV_W       8     divisor/phase field width per channel
//  DEF_DIV     2     divisor loaded into every channel at reset
//  LOCK_CYCLES 1024  consecutive synced-locked cycles required before RUN (>=1)
// PORTS
//  refclk       in   1             sole clock; all logic on rising edge
//  rst          in   1             synchronous, active-high reset
//  pll_locked   in   1             PLL lock flag, asynchronous to refclk
//  cfg_valid    in   1             new config offered
//  cfg_ready    out  1             config accepted when cfg_valid & cfg_ready
//  cfg_div      in   NUM_CH*DIV_W  divisor per channel, ch c at [c*DIV_W +: DIV_W]
//  cfg_phase    in   NUM_CH*DIV_W  start count per channel, same packing
//  ce_out       out  NUM_CH        1-cycle enable pulse per divided period
//  divclk_out   out  NUM_CH        divided square wave
//  locked       out  1             high only in RUN
//  state_out    out  2             FSM state, for debug
// BEHAVIOUR
//  - Reset: FSM=WAIT_LOCK(0), stability counter=0, div regs=DEF_DIV, phase regs=0,
//    cnt[c]=0; outputs ce_out=0, divclk_out=0, locked=0, cfg_ready=0, state_out=0.
//  - pll_locked passes through a 2-flop synchroniser (lk_s); the sync flops reset to 0.
//  - FSM states: WAIT_LOCK=0, STABILIZE=1, RUN=2 (3 is unused and recovers to WAIT_LOCK).
//    WAIT_LOCK -> STABILIZE when lk_s=1; the counter clears.
//    STABILIZE: the counter increments each cycle with lk_s=1. When it reaches
//    LOCK_CYCLES-1 with lk_s=1, the FSM goes to RUN.
//    Any state: lk_s=0 -> WAIT_LOCK next cycle. The counter clears and locked drops on
//    the same edge.
//  - Effective divisor N[c] = (div==0) ? 1 : div. Effective phase P[c] = (phase<N) ? phase : 0.
//  - Outside RUN: cnt[c] is held at P[c]. On the first RUN cycle cnt[c]=P[c]. In RUN,
//    each cycle cnt <= (cnt==N-1) ? 0 : cnt+1.
//  - ce_out and divclk_out are registered, with 1-cycle latency from cnt:
//    ce_out[c](t+1)     = RUN(t) & (cnt[c](t)==N-1)
//    divclk_out[c](t+1) = RUN(t) & (cnt[c](t) < N/2), using floor.
//    Consequences: N=1 gives ce every cycle and divclk constant 0. Odd N gives a low
//    duty of ceil(N/2)/N.
//  - All outputs are forced to 0 on the cycle after leaving RUN. No partial pulses follow.
//  - Config: cfg_ready=1 in every state except the single cycle after an accept, when
//    it is 0.
//    On accept, div/phase regs load on that edge. The next cycle, every cnt reloads its
//    new P. This re-aligns all channels. ce_out and divclk_out are 0 for that one cycle,
//    then follow the rules above.
//    An accept outside RUN only updates the regs.
//  - If an accept coincides with a lk_s fall, both take effect: the regs update and the
//    FSM goes to WAIT_LOCK.
//  - rst asserted mid-RUN returns every register to its reset value on that edge.
// TESTING
//  1. rst 4 cyc, pll_locked=1, LOCK_CYCLES=16 -> locked rises exactly 2+1+16 cycles
//     after rst release; ce/divclk stay 0 before that.
//  2. RUN with ch0 div=4 phase=0 -> ce_out[0] first high on RUN cycle 4, then every 4;
//     divclk_out[0] follows 1,1,0,0 from RUN cycle 1.
//  3. ch1 div=5 phase=2; ch2 div=0 -> ch1 ce on RUN cycle 3 then period 5, divclk
//     low 3 of 5; ch2 ce every cycle, divclk 0.
//  4. Drop pll_locked mid-RUN -> locked and all outputs 0 within 3 cycles. Re-assert ->
//     a full LOCK_CYCLES wait occurs before RUN again.
//  5. cfg accept in RUN, div=3 on all channels -> cfg_ready low 1 cycle, outputs 0 for
//     1 cycle, then all ce_out pulses coincide with period 3.
//  6. Phase >= div (div=4, phase=7) is treated as phase 0. rst mid-RUN -> all outputs 0
//     next cycle and the div regs return to DEF_DIV.

Source files
------------

// File: rtl/pll_clk_div_bank.sv
// pll_clk_div_bank
//   Clock-enable / divider bank behind the PLL wrapper. The asynchronous PLL lock flag
//   is synchronised, then qualified by a stability wait. Once the bank is running,
//   NUM_CH divided square waves and one-cycle enable pulses are produced in the refclk
//   domain. Divisors and start phases are runtime programmable through a valid/ready
//   config port. An accepted config re-aligns every channel.
//
// Ports
//   refclk      in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   cfg_valid   in   new divisor/phase set offered
//   cfg_ready   out  config accepted when cfg_valid & cfg_ready
//   cfg_div     in   divisor per channel, ch c at [c*DIV_W +: DIV_W]
//   cfg_phase   in   start count per channel, same packing
//   ce_out      out  one-cycle enable pulse per divided period
//   divclk_out  out  divided square wave
//   locked      out  high only while the FSM is in RUN
//   state_out   out  FSM state for debug (0 WAIT_LOCK, 1 STABILIZE, 2 RUN)
module pll_clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       divclk_out,
  output logic                    locked,
  output logic [1:0]              state_out
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    UNUSED    = 2'd3
  } state_t;

  state_t   state_reg, state_next;
  logic [LCW-1:0] stab_reg, stab_next;
  logic     lk_meta_reg, lk_s_reg;
  logic     ready_reg;
  logic     reload_reg;
  logic     accept;
  logic     run_now;
  logic     out_en;
  logic [NUM_CH*DIV_W-1:0] div_reg, phase_reg;

  assign accept  = cfg_valid & ready_reg;
  assign run_now = (state_reg == RUN);
  // Outputs are only allowed while RUN persists across the edge, so the edge that
  // leaves RUN also clears every output together with locked. The cycle after an
  // accept is blanked while the counters reload.
  assign out_en  = run_now && (state_next == RUN) && !reload_reg;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_meta_reg <= 1'b0;
      lk_s_reg    <= 1'b0;
    end else begin
      lk_meta_reg <= pll_locked;
      lk_s_reg    <= lk_meta_reg;
    end
  end

  // Lock qualification FSM: state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= WAIT_LOCK;
      stab_reg  <= '0;
    end else begin
      state_reg <= state_next;
      stab_reg  <= stab_next;
    end
  end

  // Lock qualification FSM: next state. Losing lock wins over everything.
  always_comb begin
    state_next = state_reg;
    stab_next  = stab_reg;
    if (!lk_s_reg) begin
      state_next = WAIT_LOCK;
      stab_next  = '0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          state_next = STABILIZE;
          stab_next  = '0;
        end
        STABILIZE: begin
          if (stab_reg == LOCK_LAST) state_next = RUN;
          else                       stab_next  = stab_reg + LCW'(1);
        end
        RUN: begin
          state_next = RUN;
        end
        default: begin
          state_next = WAIT_LOCK;
          stab_next  = '0;
        end
      endcase
    end
  end

  // Config handshake. Ready drops for exactly the cycle after an accept; an accept
  // taken in RUN schedules a counter reload for that following cycle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      ready_reg  <= 1'b0;
      reload_reg <= 1'b0;
      div_reg    <= {NUM_CH{DIV_W'(DEF_DIV)}};
      phase_reg  <= '0;
    end else begin
      ready_reg  <= !accept;
      reload_reg <= accept && run_now;
      if (accept) begin
        div_reg   <= cfg_div;
        phase_reg <= cfg_phase;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] div_c, phase_c;
      logic [DIV_W-1:0] n_eff, p_eff, last_cnt, half_cnt;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             ce_reg, dc_reg;

      assign div_c    = div_reg[gi*DIV_W +: DIV_W];
      assign phase_c  = phase_reg[gi*DIV_W +: DIV_W];
      // A zero divisor behaves as divide-by-1; an out-of-range phase starts at 0.
      assign n_eff    = (div_c == '0) ? DIV_W'(1) : div_c;
      assign p_eff    = (phase_c < n_eff) ? phase_c : '0;
      assign last_cnt = n_eff - DIV_W'(1);
      assign half_cnt = n_eff >> 1;

      // Counter parks at its phase outside RUN so all channels start aligned, and
      // reloads the phase on the post-accept cycle to re-align after a reconfig.
      always_comb begin
        cnt_next = p_eff;
        if (run_now && !reload_reg) begin
          cnt_next = (cnt_reg == last_cnt) ? '0 : cnt_reg + DIV_W'(1);
        end
      end

      always_ff @(posedge refclk) begin
        if (rst) begin
          cnt_reg <= '0;
          ce_reg  <= 1'b0;
          dc_reg  <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          ce_reg  <= out_en && (cnt_reg == last_cnt);
          dc_reg  <= out_en && (cnt_reg < half_cnt);
        end
      end

      assign ce_out[gi]     = ce_reg;
      assign divclk_out[gi] = dc_reg;
    end
  endgenerate

  assign cfg_ready = ready_reg;
  assign locked    = run_now;
  assign state_out = state_reg;

endmodule

// File: tb/tb_pll_clk_div_bank.sv
module tb_pll_clk_div_bank;
  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int DEF_DIV     = 2;
  localparam int LOCK_CYCLES = 16;
  localparam int LOCK_LAT    = 2 + 1 + LOCK_CYCLES;

  logic                    refclk = 1'b0;
  logic                    rst = 1'b1;
  logic                    pll_locked = 1'b0;
  logic                    cfg_valid = 1'b0;
  logic                    cfg_ready;
  logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
  logic [NUM_CH*DIV_W-1:0] cfg_phase = '0;
  logic [NUM_CH-1:0]       ce_out, divclk_out;
  logic                    locked;
  logic [1:0]              state_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 refclk = ~refclk;

  pll_clk_div_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .ce_out(ce_out), .divclk_out(divclk_out),
    .locked(locked), .state_out(state_out)
  );

  typedef struct {
    logic       pll_in;
    logic [3:0] exp_ce;
    logic [3:0] exp_dc;
    logic       exp_locked;
  } vec_t;

  vec_t run_vec[11];
  logic [3:0] re_ce[7];
  logic [3:0] re_dc[7];

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Steps until locked rises (bounded), checking the outputs stayed quiet meanwhile.
  task automatic wait_lock(input string name, input int start);
    int   n;
    logic noisy;
    n = start;
    noisy = 1'b0;
    while (n < 80) begin
      step();
      n++;
      if (locked) break;
      if (ce_out != '0 || divclk_out != '0) noisy = 1'b1;
    end
    chk({name, " lock latency"}, n, LOCK_LAT);
    chk({name, " quiet before lock"}, {31'd0, noisy}, 0);
    chk({name, " state RUN"}, {30'd0, state_out}, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected outputs for RUN cycles 0..10 with
    // ch0 div4 ph0, ch1 div5 ph2, ch2 div0, ch3 div4 ph7 (-> ph0).
    run_vec[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1};
    run_vec[1]  = '{1'b1, 4'b0100, 4'b1001, 1'b1};
    run_vec[2]  = '{1'b1, 4'b0100, 4'b1001, 1'b1};
    run_vec[3]  = '{1'b1, 4'b0110, 4'b0000, 1'b1};
    run_vec[4]  = '{1'b1, 4'b1101, 4'b0010, 1'b1};
    run_vec[5]  = '{1'b1, 4'b0100, 4'b1011, 1'b1};
    run_vec[6]  = '{1'b1, 4'b0100, 4'b1001, 1'b1};
    run_vec[7]  = '{1'b1, 4'b0100, 4'b0000, 1'b1};
    run_vec[8]  = '{1'b1, 4'b1111, 4'b0000, 1'b1};
    run_vec[9]  = '{1'b1, 4'b0100, 4'b1011, 1'b1};
    run_vec[10] = '{1'b1, 4'b0100, 4'b1011, 1'b1};
    // After a div=3/phase=0 reconfig: blank cycle, then aligned period-3 pattern.
    re_ce = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
    re_dc = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};

    // Reset state and lock latency, with a config accepted while still waiting.
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (4) step();
    chk("reset locked", {31'd0, locked}, 0);
    chk("reset ce_out", {28'd0, ce_out}, 0);
    chk("reset divclk", {28'd0, divclk_out}, 0);
    chk("reset cfg_ready", {31'd0, cfg_ready}, 0);
    chk("reset state", {30'd0, state_out}, 0);
    rst = 1'b0;
    step();
    chk("ready after reset", {31'd0, cfg_ready}, 1);
    cfg_valid = 1'b1;
    cfg_div   = {8'd4, 8'd0, 8'd5, 8'd4};
    cfg_phase = {8'd7, 8'd0, 8'd2, 8'd0};
    step();
    cfg_valid = 1'b0;
    chk("ready low after accept", {31'd0, cfg_ready}, 0);
    wait_lock("initial", 2);

    // Divider patterns from the first RUN cycle.
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        pll_locked = run_vec[i].pll_in;
        step();
      end
      chk($sformatf("run%0d ce", i), {28'd0, ce_out}, {28'd0, run_vec[i].exp_ce});
      chk($sformatf("run%0d divclk", i), {28'd0, divclk_out}, {28'd0, run_vec[i].exp_dc});
      chk($sformatf("run%0d locked", i), {31'd0, locked}, {31'd0, run_vec[i].exp_locked});
    end

    // Reconfig in RUN: all channels div 3 phase 0.
    cfg_valid = 1'b1;
    cfg_div   = {4{8'd3}};
    cfg_phase = '0;
    step();
    cfg_valid = 1'b0;
    chk("reconfig ready low", {31'd0, cfg_ready}, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) chk("reconfig ready back", {31'd0, cfg_ready}, 1);
      chk($sformatf("reconfig%0d ce", i), {28'd0, ce_out}, {28'd0, re_ce[i]});
      chk($sformatf("reconfig%0d divclk", i), {28'd0, divclk_out}, {28'd0, re_dc[i]});
    end

    // Lock loss: two sync flops, then WAIT_LOCK with all outputs cleared.
    pll_locked = 1'b0;
    step();
    step();
    chk("lock loss still locked at 2", {31'd0, locked}, 1);
    step();
    chk("lock loss locked", {31'd0, locked}, 0);
    chk("lock loss state", {30'd0, state_out}, 0);
    chk("lock loss ce", {28'd0, ce_out}, 0);
    chk("lock loss divclk", {28'd0, divclk_out}, 0);
    pll_locked = 1'b1;
    wait_lock("relock", 0);
    step();
    chk("relock run1 divclk", {28'd0, divclk_out}, 4'hF);
    step();
    step();
    chk("relock run3 ce", {28'd0, ce_out}, 4'hF);

    // Reset mid-RUN: everything back to reset values, divisors back to DEF_DIV.
    rst = 1'b1;
    step();
    chk("midrst locked", {31'd0, locked}, 0);
    chk("midrst ce", {28'd0, ce_out}, 0);
    chk("midrst divclk", {28'd0, divclk_out}, 0);
    chk("midrst state", {30'd0, state_out}, 0);
    chk("midrst cfg_ready", {31'd0, cfg_ready}, 0);
    rst = 1'b0;
    wait_lock("post-reset", 0);
    step();
    chk("defdiv run1 ce", {28'd0, ce_out}, 0);
    chk("defdiv run1 divclk", {28'd0, divclk_out}, 4'hF);
    step();
    chk("defdiv run2 ce", {28'd0, ce_out}, 4'hF);
    chk("defdiv run2 divclk", {28'd0, divclk_out}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
